// File: rtl/board_game_engine_if.sv
// ============================================================================
// Module   : board_game_engine_if
// Purpose  : Move handshake, status and cell read-port bundle for the engine.
//            Optional BGE_WIN_MASK_EN adds the rd_win highlight output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface board_game_engine_if #(
  parameter int N = 3
);
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N * N + 1);

  logic             i_new_game;
  logic             i_move_valid;
  logic             o_move_ready;
  logic [IDX_W-1:0] i_move_row;
  logic [IDX_W-1:0] i_move_col;
  logic             o_move_err;
  logic             o_turn;
  logic [CNT_W-1:0] o_move_count;
  logic             o_game_over;
  logic [1:0]       o_winner;
  logic [IDX_W-1:0] i_rd_row;
  logic [IDX_W-1:0] i_rd_col;
  logic [1:0]       o_rd_state;
`ifdef BGE_WIN_MASK_EN
  logic             o_rd_win;
`endif

  modport slave (
    input  i_new_game, i_move_valid, i_move_row, i_move_col, i_rd_row, i_rd_col,
    output o_move_ready, o_move_err, o_turn, o_move_count, o_game_over,
    output o_winner, o_rd_state
`ifdef BGE_WIN_MASK_EN
    , output o_rd_win
`endif
  );

  modport master (
    output i_new_game, i_move_valid, i_move_row, i_move_col, i_rd_row, i_rd_col,
    input  o_move_ready, o_move_err, o_turn, o_move_count, o_game_over,
    input  o_winner, o_rd_state
`ifdef BGE_WIN_MASK_EN
    , input o_rd_win
`endif
  );
endinterface

`default_nettype wire

// File: rtl/board_game_engine.sv
// ============================================================================
// Module   : board_game_engine
// Purpose  : N x N, K-in-a-row game engine: board, turns, move checks and a
//            fixed-length win/draw scan. Option: BGE_WIN_MASK_EN (win mask).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module board_game_engine #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  board_game_engine_if.slave bus
);
  localparam int IDX_W  = (N > 2) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N * N + 1);
  localparam int CELL_W = $clog2(N * N);
  localparam int STEPS  = 2 * (K - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_OVER = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [1:0]       r_board [N*N];
  logic             r_turn, r_player, r_prime, r_frozen, r_win, r_err;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_winner, r_rd_state;
  logic [IDX_W-1:0] r_org_r, r_org_c;
  logic [1:0]       r_dir;
  logic [3:0]       r_step, r_run;

  logic             w_ready, w_over, w_hs, w_mv_in, w_mv_ok, w_legal, w_illegal;
  logic [CELL_W-1:0] w_mv_idx, w_sc_idx, w_rd_idx;
  logic             w_rd_in;
  logic             w_neg, w_on, w_side_start, w_match, w_dir_end, w_dir_win;
  logic             w_scan_active, w_scan_last, w_win_final, w_full;
  logic [3:0]       w_run_nxt;
  logic [1:0]       w_pcode;
  int               w_d, w_dr, w_dc, w_tr, w_tc;

  assign w_hs      = bus.i_move_valid && w_ready && !bus.i_new_game;
  assign w_mv_in   = (int'(bus.i_move_row) < N) && (int'(bus.i_move_col) < N);
  assign w_mv_idx  = CELL_W'(int'(bus.i_move_row) * N + int'(bus.i_move_col));
  assign w_mv_ok   = w_mv_in && (r_board[w_mv_idx] == 2'b00);
  assign w_legal   = w_hs && w_mv_ok;
  assign w_illegal = w_hs && !w_mv_ok;

  // One scan step: walk d cells from the origin along the current direction,
  // negative side first; a frozen side idles until the next side starts.
  always_comb begin
    w_neg = int'(r_step) < (K - 1);
    w_d   = w_neg ? int'(r_step) + 1 : int'(r_step) - K + 2;
    case (r_dir)
      2'd0:    begin w_dr = 0;  w_dc = 1; end
      2'd1:    begin w_dr = 1;  w_dc = 0; end
      2'd2:    begin w_dr = 1;  w_dc = 1; end
      default: begin w_dr = -1; w_dc = 1; end
    endcase
    if (w_neg) begin
      w_dr = -w_dr;
      w_dc = -w_dc;
    end
    w_tr          = int'(r_org_r) + w_dr * w_d;
    w_tc          = int'(r_org_c) + w_dc * w_d;
    w_on          = (w_tr >= 0) && (w_tr < N) && (w_tc >= 0) && (w_tc < N);
    w_sc_idx      = w_on ? CELL_W'(w_tr * N + w_tc) : '0;
    w_pcode       = r_player ? 2'b10 : 2'b01;
    w_side_start  = (r_step == 4'd0) || (int'(r_step) == K - 1);
    w_match       = (w_side_start || !r_frozen) && w_on && (r_board[w_sc_idx] == w_pcode);
    w_run_nxt     = r_run + {3'b000, w_match};
    w_dir_end     = int'(r_step) == STEPS - 1;
    w_dir_win     = w_dir_end && (int'(w_run_nxt) >= K);
    w_scan_active = (r_state == c_SCAN) && !r_prime;
    w_scan_last   = w_scan_active && (r_dir == 2'd3) && w_dir_end;
    w_win_final   = r_win || w_dir_win;
    w_full        = r_count == CNT_W'(N * N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_new_game) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (w_legal) w_state_nxt = c_SCAN;
        c_SCAN:  if (w_scan_last) w_state_nxt = (w_win_final || w_full) ? c_OVER : c_IDLE;
        c_OVER:  w_state_nxt = c_OVER;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready = 1'b0;
    w_over  = 1'b0;
    case (r_state)
      c_IDLE:  w_ready = 1'b1;
      c_OVER:  w_over  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.i_new_game) begin
      for (int i = 0; i < N * N; i++) r_board[i] <= 2'b00;
      r_turn   <= 1'b0;
      r_player <= 1'b0;
      r_count  <= '0;
      r_winner <= 2'b00;
      r_err    <= 1'b0;
      r_prime  <= 1'b0;
      r_frozen <= 1'b0;
      r_win    <= 1'b0;
      r_org_r  <= '0;
      r_org_c  <= '0;
      r_dir    <= 2'd0;
      r_step   <= 4'd0;
      r_run    <= 4'd1;
    end else begin
      r_err <= w_illegal;
      if (w_legal) begin
        r_board[w_mv_idx] <= r_turn ? 2'b10 : 2'b01;
        r_count  <= r_count + CNT_W'(1);
        r_org_r  <= bus.i_move_row;
        r_org_c  <= bus.i_move_col;
        r_player <= r_turn;
        r_prime  <= 1'b1;
        r_frozen <= 1'b0;
        r_win    <= 1'b0;
        r_dir    <= 2'd0;
        r_step   <= 4'd0;
        r_run    <= 4'd1;
      end
      // The first SCAN cycle only settles the freshly written cell.
      if (r_state == c_SCAN && r_prime) r_prime <= 1'b0;
      if (w_scan_active) begin
        r_frozen <= !w_match;
        if (w_dir_end) begin
          r_step <= 4'd0;
          r_run  <= 4'd1;
          r_dir  <= r_dir + 2'd1;
          if (w_dir_win) r_win <= 1'b1;
        end else begin
          r_step <= r_step + 4'd1;
          r_run  <= w_run_nxt;
        end
        if (w_scan_last) begin
          if (w_win_final)  r_winner <= w_pcode;
          else if (w_full)  r_winner <= 2'b11;
          else              r_turn   <= !r_turn;
        end
      end
    end
  end

  assign w_rd_in  = (int'(bus.i_rd_row) < N) && (int'(bus.i_rd_col) < N);
  assign w_rd_idx = CELL_W'(int'(bus.i_rd_row) * N + int'(bus.i_rd_col));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_state <= 2'b00;
    else        r_rd_state <= w_rd_in ? r_board[w_rd_idx] : 2'b00;
  end

`ifdef BGE_WIN_MASK_EN
  logic [N*N-1:0]    r_dir_mask, r_win_mask, w_hit_mask, w_org_mask;
  logic [CELL_W-1:0] w_org_idx;
  logic              r_rd_win;

  assign w_org_idx = CELL_W'(int'(r_org_r) * N + int'(r_org_c));

  always_comb begin
    w_hit_mask = '0;
    w_org_mask = '0;
    if (w_match) w_hit_mask[w_sc_idx] = 1'b1;
    w_org_mask[w_org_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.i_new_game) begin
      r_dir_mask <= '0;
      r_win_mask <= '0;
    end else if (w_legal) begin
      r_dir_mask <= '0;
    end else if (w_scan_active) begin
      if (w_dir_end) begin
        r_dir_mask <= '0;
        if (w_dir_win) r_win_mask <= r_win_mask | r_dir_mask | w_hit_mask | w_org_mask;
      end else begin
        r_dir_mask <= r_dir_mask | w_hit_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_win <= 1'b0;
    else        r_rd_win <= w_rd_in ? r_win_mask[w_rd_idx] : 1'b0;
  end

  assign bus.o_rd_win = r_rd_win;
`endif

  assign bus.o_move_ready = w_ready;
  assign bus.o_game_over  = w_over;
  assign bus.o_move_err   = r_err;
  assign bus.o_turn       = r_turn;
  assign bus.o_move_count = r_count;
  assign bus.o_winner     = r_winner;
  assign bus.o_rd_state   = r_rd_state;
endmodule

`default_nettype wire

// File: tb/tb_board_game_engine.sv
// ============================================================================
// Module   : tb_board_game_engine
// Purpose  : Checks a 3x3/K=3 and a 5x5/K=4 engine against a board-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_game_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_game_engine_if #(.N(3)) bus3 ();
  board_game_engine_if #(.N(5)) bus5 ();

  board_game_engine #(.N(3), .K(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  board_game_engine #(.N(5), .K(4)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  int errors = 0;
  int checks = 0;

  int mb [2][8][8];
  int mturn [2];
  int mcnt [2];
  int mwin [2];
  bit mover [2];

  logic        s_ready [2], s_err [2], s_turn [2], s_over [2];
  logic [1:0]  s_win [2], s_rd [2];
  logic [31:0] s_cnt [2];

  assign s_ready[0] = bus3.o_move_ready;  assign s_ready[1] = bus5.o_move_ready;
  assign s_err[0]   = bus3.o_move_err;    assign s_err[1]   = bus5.o_move_err;
  assign s_turn[0]  = bus3.o_turn;        assign s_turn[1]  = bus5.o_turn;
  assign s_over[0]  = bus3.o_game_over;   assign s_over[1]  = bus5.o_game_over;
  assign s_win[0]   = bus3.o_winner;      assign s_win[1]   = bus5.o_winner;
  assign s_rd[0]    = bus3.o_rd_state;    assign s_rd[1]    = bus5.o_rd_state;
  assign s_cnt[0]   = 32'(bus3.o_move_count);
  assign s_cnt[1]   = 32'(bus5.o_move_count);

  function automatic int nof(int s); return (s == 0) ? 3 : 5; endfunction
  function automatic int kof(int s); return (s == 0) ? 3 : 4; endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(); @(negedge clk); endtask

  task automatic drive(int s, bit ng, bit v, int r, int c);
    if (s == 0) begin
      bus3.i_new_game = ng; bus3.i_move_valid = v;
      bus3.i_move_row = 2'(r); bus3.i_move_col = 2'(c);
    end else begin
      bus5.i_new_game = ng; bus5.i_move_valid = v;
      bus5.i_move_row = 3'(r); bus5.i_move_col = 3'(c);
    end
  endtask

  task automatic rdaddr(int s, int r, int c);
    if (s == 0) begin bus3.i_rd_row = 2'(r); bus3.i_rd_col = 2'(c); end
    else        begin bus5.i_rd_row = 3'(r); bus5.i_rd_col = 3'(c); end
  endtask

  task automatic mclear(int s);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mb[s][r][c] = 0;
    mturn[s] = 0; mcnt[s] = 0; mwin[s] = 0; mover[s] = 1'b0;
  endtask

  // Longest run of player p through (r,c), each side capped at k-1 cells.
  function automatic bit mwins(int s, int r, int c, int p);
    int dr [4] = '{0, 1, 1, -1};
    int dc [4] = '{1, 0, 1, 1};
    int n = nof(s);
    int k = kof(s);
    for (int d = 0; d < 4; d++) begin
      int run = 1;
      for (int sg = -1; sg <= 1; sg += 2) begin
        for (int i = 1; i < k; i++) begin
          int rr = r + sg * dr[d] * i;
          int cc = c + sg * dc[d] * i;
          if (rr < 0 || rr >= n || cc < 0 || cc >= n) break;
          if (mb[s][rr][cc] != p + 1) break;
          run++;
        end
      end
      if (run >= k) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk_status(int s, string tag);
    chk({tag, "_turn"},  s_turn[s],  mturn[s]);
    chk({tag, "_count"}, s_cnt[s],   mcnt[s]);
    chk({tag, "_winner"}, s_win[s],  mwin[s]);
    chk({tag, "_over"},  s_over[s],  mover[s]);
    chk({tag, "_ready"}, s_ready[s], !mover[s]);
  endtask

  task automatic chk_reset(int s, string tag);
    chk({tag, "_ready"}, s_ready[s], 1);
    chk({tag, "_err"},   s_err[s],   0);
    chk({tag, "_turn"},  s_turn[s],  0);
    chk({tag, "_count"}, s_cnt[s],   0);
    chk({tag, "_over"},  s_over[s],  0);
    chk({tag, "_winner"}, s_win[s],  0);
    chk({tag, "_rd"},    s_rd[s],    0);
  endtask

  task automatic read_all(int s);
    int n = nof(s);
    for (int r = 0; r <= n; r++) begin
      for (int c = 0; c <= n; c++) begin
        if (r == n || c == n) if (r != 0 && c != 0) continue;
        rdaddr(s, r, c);
        step();
        chk($sformatf("rd%0d_%0d_%0d", s, r, c), s_rd[s],
            (r < n && c < n) ? mb[s][r][c] : 0);
      end
    end
  endtask

  task automatic move(int s, int r, int c);
    int n = nof(s);
    int k = kof(s);
    int cyc = 0;
    int p;
    bit legal;
    while (!s_ready[s] && cyc < 200) begin step(); cyc++; end
    chk("ready_wait", s_ready[s], 1);
    legal = (r < n) && (c < n) && (mb[s][r][c] == 0);
    drive(s, 0, 1, r, c);
    step();
    drive(s, 0, 0, 0, 0);
    if (!legal) begin
      chk("err_pulse", s_err[s], 1);
      chk_status(s, "illegal");
      step();
      chk("err_clear", s_err[s], 0);
      chk("ready_after_err", s_ready[s], 1);
    end else begin
      chk("no_err", s_err[s], 0);
      chk("ready_fall", s_ready[s], 0);
      p = mturn[s];
      mb[s][r][c] = p + 1;
      mcnt[s]++;
      repeat (8 * (k - 1)) step();
      chk("scan_busy_ready", s_ready[s], 0);
      chk("scan_busy_over", s_over[s], 0);
      step();
      if (mwins(s, r, c, p)) begin
        mover[s] = 1'b1; mwin[s] = p + 1;
      end else if (mcnt[s] == n * n) begin
        mover[s] = 1'b1; mwin[s] = 3;
      end else begin
        mturn[s] = 1 - mturn[s];
      end
      chk_status(s, "scan_end");
    end
  endtask

  task automatic new_game(int s);
    drive(s, 1, 1, 0, 0);
    step();
    drive(s, 0, 0, 0, 0);
    mclear(s);
    chk("ng_err", s_err[s], 0);
    chk_status(s, "ng");
  endtask

  initial begin
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    rdaddr(0, 0, 0); rdaddr(1, 0, 0);
    mclear(0); mclear(1);
    repeat (3) step();
    chk_reset(0, "rst3");
    chk_reset(1, "rst5");
    rst_n = 1'b1;
    step();
    read_all(0);

    // Row-0 win for P1 on 3x3
    move(0, 0, 0); move(0, 1, 0); move(0, 0, 1); move(0, 1, 1); move(0, 0, 2);
    chk("row_win_winner", s_win[0], 2'b01);
    chk("row_win_count", s_cnt[0], 5);
    drive(0, 0, 1, 2, 2);
    step();
    drive(0, 0, 0, 0, 0);
    chk("over_no_err", s_err[0], 0);
    chk("over_ready", s_ready[0], 0);
    chk("over_count", s_cnt[0], 5);
    read_all(0);

    // Occupied cell and out-of-range row
    new_game(0);
    read_all(0);
    move(0, 1, 1);
    move(0, 1, 1);
    move(0, 3, 0);
    chk("illegal_turn", s_turn[0], 1);
    chk("illegal_count", s_cnt[0], 1);

    // Full board, no line
    new_game(0);
    move(0, 0, 0); move(0, 0, 1); move(0, 0, 2); move(0, 1, 1); move(0, 1, 0);
    move(0, 1, 2); move(0, 2, 1); move(0, 2, 0); move(0, 2, 2);
    chk("draw_winner", s_win[0], 2'b11);
    read_all(0);

    // Anti-diagonal win for P2 on 5x5, K=4
    new_game(1);
    move(1, 0, 0); move(1, 4, 0); move(1, 0, 2); move(1, 3, 1);
    move(1, 0, 4); move(1, 2, 2); move(1, 4, 4); move(1, 1, 3);
    chk("anti_winner", s_win[1], 2'b10);
    read_all(1);

    // new_game during the scan of a would-be winning move
    new_game(0);
    move(0, 0, 0); move(0, 1, 0); move(0, 0, 1); move(0, 1, 1);
    drive(0, 0, 1, 0, 2);
    step();
    drive(0, 0, 0, 0, 0);
    repeat (4) step();
    new_game(0);
    repeat (30) step();
    chk("abort_still_idle", s_over[0], 0);
    read_all(0);

    // Randomised games on both boards
    for (int g = 0; g < 6; g++) begin
      int s = g % 2;
      int n = nof(s);
      int tries = 0;
      new_game(s);
      while (!mover[s] && tries < 60) begin
        move(s, int'($urandom_range(0, n)), int'($urandom_range(0, n)));
        tries++;
      end
      read_all(s);
    end

    // Asynchronous reset in the middle of a scan
    new_game(1);
    move(1, 2, 2);
    drive(1, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 0);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk_reset(0, "arst3");
    chk_reset(1, "arst5");
    step();
    rst_n = 1'b1;
    mclear(0); mclear(1);
    step();
    chk_status(1, "post_rst");
    read_all(0);
    read_all(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/board_game_engine.md
# board_game_engine

Parametrised N×N, K-in-a-row board-game state engine: the successor to the fixed 3×3 tic-tac-toe logic embedded in the VGA controller.
- Owns board storage, turn alternation and move validation.
- Runs a deterministic sequential win/draw scan after every move.
- Exposes a registered cell read port that the VGA pixel pipeline uses to choose X/O/empty artwork per cell.
- Sits between the debounced button/keyboard front end (move source) and the VGA renderer (read port consumer).

## Interface
- N, 3: board side, 3..8.
- K, 3: run length needed to win, 3..N.
- IDX_W, $clog2(N) (min 1): row/column index width.
- CNT_W, $clog2(N*N+1): move counter width.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; asserting clears all state.
- new_game  in  1  synchronous clear of board, counters and result; dominates every other input.
- move_valid  in  1  move request.
- move_ready  out  1  engine can accept a move.
- move_row, move_col  in  IDX_W  target cell.
- move_err  out  1  one-cycle pulse; the accepted move was illegal.
- turn  out  1  player to move next: 0 = P1 (X), 1 = P2 (O).
- move_count  out  CNT_W  legal moves placed.
- game_over  out  1  win or draw reached.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- rd_row, rd_col  in  IDX_W  read address.
- rd_state  out  2  registered cell state: 00 empty, 01 P1, 10 P2.

## Operation
- States:
  - IDLE: move_ready=1.
  - SCAN: checks the last move.
  - OVER: game_over=1.
- A handshake completes when move_valid && move_ready.
- Illegal move (row or col ≥ N, or cell non-empty):
  - move_err pulses the next cycle.
  - Board, turn and move_count are unchanged; the FSM stays in IDLE.
- Legal move:
  - The cell is written with turn+1 and move_count increments.
  - The FSM enters SCAN with origin (r,c) and player p = turn.
- SCAN visits four directions in order: horizontal, vertical, diagonal (↘), anti-diagonal (↗).
  - Each direction takes exactly 2(K-1) cycles: K-1 steps on the negative side, then K-1 on the positive side.
  - The run counter starts at 1 per direction. It increments while the visited cell is on-board and equals p. The first mismatch or board edge freezes that side (remaining steps idle).
  - Total SCAN length is always 8(K-1) cycles.
- At the end of each direction, a run ≥ K latches a win flag.
- Leaving SCAN:
  - win → OVER, winner = p+1.
  - else move_count == N*N → OVER, winner = 11.
  - else → IDLE with turn toggled.
- OVER holds until new_game. Move attempts are not accepted (move_ready=0).
- The read port is a pure registered lookup, independent of the FSM. Out-of-range addresses return 00.

## Timing
- Reset values:
  - move_ready=1, move_err=0, turn=0, move_count=0, game_over=0, winner=00, rd_state=00.
  - Board empty, FSM in IDLE.
- move_ready falls the cycle after a legal handshake. It rises 8(K-1)+1 cycles after the handshake edge if the game is not over.
- Board update is visible on rd_state 2 cycles after the handshake edge (write, then registered read).
- winner and game_over assert on the same edge as the SCAN→OVER transition.
- new_game in any state, including mid-SCAN:
  - Next cycle the board is empty, FSM is in IDLE, turn=0, move_count=0, winner=00, and move_err=0.
  - A move_valid in the same cycle is ignored.
- Reset asserted mid-SCAN aborts immediately to reset values.
- move_err and a legal acceptance are mutually exclusive. There is no back-to-back move while in SCAN.

## Configuration
- BGE_WIN_MASK_EN:
  - Defined: add an output rd_win (1 bit, registered with rd_state) and an N*N-bit win mask.
    - The mask is loaded in SCAN with the origin plus every matched cell of each direction whose run ≥ K.
    - Multiple winning directions OR together. The mask is cleared by reset/new_game.
    - The renderer uses it to highlight the winning line.
  - Undefined: no port, no mask flops. Behaviour is otherwise identical.

## Test plan
- N=3,K=3: P1 (0,0), P2 (1,0), P1 (0,1), P2 (1,1), P1 (0,2) -> after the last scan winner=01, game_over=1, move_count=5, move_ready stays 0; with mask, rd_win=1 only at row 0.
- Move on occupied (1,1), then move_row=3 -> two move_err pulses, turn and move_count unchanged, move_ready back to 1 next cycle.
- N=3 full board with no line (X O X / X O O / O X X order) -> winner=11 after 9th scan.
- N=5,K=4: anti-diagonal (4,0),(3,1),(2,2),(1,3) by P2 -> winner=10; measure the handshake-to-game_over gap = 25 cycles (8(K-1)=24 SCAN cycles plus 1).
- new_game asserted on the 5th SCAN cycle of a would-be winning move -> next cycle board empty, winner=00, turn=0, move_ready=1.
- reset low mid-game for 1 cycle -> all outputs at reset values asynchronously; rd_state reads 00 everywhere.
